ccd_cds_sampler: RTL and testbench

- Receive end of the CCD phase clocks (phi_p, phi_l1, phi_l2, phi_r).
- Tracks the phase sequence and samples an external ADC word twice per pixel: reset level after phi_r falls, signal level after phi_l2 falls.
- Outputs the correlated-double-sampled difference as a valid/ready pixel stream, buffered in a small FIFO, with end-of-line marking.
- Sits between the phase-clock generator plus ADC and the readout/DMA path.

---
 rtl/ccd_cds_sampler_pkg.sv | 21 ++
 rtl/ccd_cds_sampler_if.sv | 14 +
 rtl/ccd_cds_sampler_pix_fifo.sv | 51 +++++
 rtl/ccd_cds_sampler.sv | 179 +++++++++++++++++
 tb/tb_ccd_cds_sampler.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ccd_cds_sampler_pkg.sv
// Shared types and defaults for the CCD correlated-double-sampling receiver.
// The optional zero-clamp of the CDS difference is selected with CCD_CDS_CLAMP_EN.
package ccd_pkg;

    localparam int CCD_ADC_W           = 8;
    localparam int CCD_PIXELS_PER_LINE = 16;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_R   = 3'd1,
        SETTLE_R = 3'd2,
        WAIT_S   = 3'd3,
        SETTLE_S = 3'd4
    } cds_state_t;

    typedef struct packed {
        logic [CCD_ADC_W-1:0] data;
        logic                 last;
    } pix_entry_t;

endpackage

// File: rtl/ccd_cds_sampler_if.sv
// Pixel stream from the CDS sampler to the readout path.
// Handshake: a beat transfers on a rising clk edge where pix_valid && pix_ready;
// while pix_valid is high, pix_data/pix_last stay stable until that transfer.
interface ccd_cds_sampler_if #(
    parameter int ADC_W = 8
) ();
    logic [ADC_W-1:0] pix_data;
    logic             pix_last;
    logic             pix_valid;
    logic             pix_ready;

    modport master (output pix_data, output pix_last, output pix_valid, input pix_ready);
    modport slave  (input pix_data, input pix_last, input pix_valid, output pix_ready);
endinterface

// File: rtl/ccd_cds_sampler_pix_fifo.sv
// First-word-fall-through FIFO for pixel entries; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module ccd_pix_fifo #(
    parameter int W     = 9,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_pop;
    logic          do_push;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    // Head is forced to zero when empty so the stream reads 0 out of reset.
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/ccd_cds_sampler.sv
// CCD phase-clock receiver: samples reset and signal levels per pixel and
// streams their difference. Define CCD_CDS_CLAMP_EN to clamp negative results to 0.
module ccd_cds_sampler
    import ccd_pkg::*;
#(
    parameter int ADC_W           = CCD_ADC_W,
    parameter int PIXELS_PER_LINE = CCD_PIXELS_PER_LINE,
    parameter int SETTLE          = 2,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               phi_p,
    input  logic                               phi_l1,
    input  logic                               phi_l2,
    input  logic                               phi_r,
    input  logic [ADC_W-1:0]                   adc_data,
    ccd_cds_sampler_if.master                  pix,
    output logic [$clog2(PIXELS_PER_LINE)-1:0] pix_idx,
    output logic                               ovf,
    output logic                               seq_err,
    input  logic                               clr_err,
    output cds_state_t                         fsm_state
);
    localparam int IDX_W = $clog2(PIXELS_PER_LINE);

    typedef struct packed {
        logic [ADC_W-1:0] data;
        logic             last;
    } entry_t;

    // Registered phases {p, l1, l2, r} and their one-cycle-older copy.
    logic [3:0] ph_q;
    logic [3:0] ph_qq;
    logic       p_rise;
    logic       l2_fall;
    logic       r_fall;
    logic       unused_l1_edge;

    cds_state_t       state, state_n;
    logic [3:0]       cnt, cnt_n;
    logic [IDX_W-1:0] idx, idx_n;
    logic [ADC_W-1:0] rst_lvl, rst_lvl_n;
    logic [ADC_W-1:0] diff;
    logic             push;
    logic             is_last;
    logic             seq_set;
    logic             ovf_set;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    entry_t           push_entry;
    entry_t           head;

    assign p_rise         =  ph_q[3] & ~ph_qq[3];
    assign l2_fall        = ~ph_q[1] &  ph_qq[1];
    assign r_fall         = ~ph_q[0] &  ph_qq[0];
    assign unused_l1_edge =  ph_q[2] ^  ph_qq[2];

    assign is_last = (idx == IDX_W'(PIXELS_PER_LINE - 1));

`ifdef CCD_CDS_CLAMP_EN
    assign diff = (rst_lvl > adc_data) ? (rst_lvl - adc_data) : '0;
`else
    assign diff = rst_lvl - adc_data;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            ph_q    <= '0;
            ph_qq   <= '0;
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            rst_lvl <= '0;
            ovf     <= 1'b0;
            seq_err <= 1'b0;
        end else begin
            ph_q    <= {phi_p, phi_l1, phi_l2, phi_r};
            ph_qq   <= ph_q;
            state   <= state_n;
            cnt     <= cnt_n;
            idx     <= idx_n;
            rst_lvl <= rst_lvl_n;
            // A fresh error in the clearing cycle keeps the flag set.
            ovf     <= (ovf & ~clr_err) | ovf_set;
            seq_err <= (seq_err & ~clr_err) | seq_set;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        idx_n     = idx;
        rst_lvl_n = rst_lvl;
        push      = 1'b0;
        seq_set   = 1'b0;
        case (state)
            IDLE: begin
                if (p_rise) begin
                    state_n = WAIT_R;
                    idx_n   = '0;
                end
            end
            WAIT_R: begin
                if (l2_fall) seq_set = 1'b1;
                if (r_fall) begin
                    state_n = SETTLE_R;
                    cnt_n   = 4'(SETTLE - 1);
                end
            end
            SETTLE_R: begin
                if (l2_fall) seq_set = 1'b1;
                if (cnt == '0) begin
                    rst_lvl_n = adc_data;
                    state_n   = WAIT_S;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            WAIT_S: begin
                if (r_fall) begin
                    seq_set = 1'b1;
                    state_n = SETTLE_R;
                    cnt_n   = 4'(SETTLE - 1);
                end else if (l2_fall) begin
                    state_n = SETTLE_S;
                    cnt_n   = 4'(SETTLE - 1);
                end
            end
            SETTLE_S: begin
                if (r_fall) begin
                    seq_set = 1'b1;
                    state_n = SETTLE_R;
                    cnt_n   = 4'(SETTLE - 1);
                end else if (cnt == '0) begin
                    push    = 1'b1;
                    idx_n   = is_last ? '0 : idx + 1'b1;
                    state_n = is_last ? IDLE : WAIT_R;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        // A new line mid-pixel abandons the partial pixel but keeps queued data.
        if (state != IDLE && p_rise) begin
            seq_set = 1'b1;
            push    = 1'b0;
            idx_n   = '0;
            cnt_n   = '0;
            state_n = WAIT_R;
        end
    end

    assign pop        = pix.pix_ready && !fifo_empty;
    assign ovf_set    = push && fifo_full && !pop;
    assign push_entry = '{data: diff, last: is_last};

    ccd_pix_fifo #(
        .W     (ADC_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .rd_data   (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign pix.pix_data  = head.data;
    assign pix.pix_last  = head.last;
    assign pix.pix_valid = !fifo_empty;
    assign pix_idx       = idx;
    assign fsm_state     = state;
endmodule

// File: tb/tb_ccd_cds_sampler.sv
// Directed bench for ccd_cds_sampler with 4-pixel lines, SETTLE=2, FIFO_DEPTH=4.
module tb_ccd_cds_sampler;
    import ccd_pkg::*;

    localparam int ADC_W = 8;
    localparam int PPL   = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             phi_p, phi_l1, phi_l2, phi_r;
    logic [ADC_W-1:0] adc_data;
    logic [1:0]       pix_idx;
    logic             ovf, seq_err, clr_err;
    cds_state_t       fsm_state;

    int total = 0;
    int bad   = 0;

`ifdef CCD_CDS_CLAMP_EN
    localparam logic [7:0] NEG_EXP = 8'd0;
`else
    localparam logic [7:0] NEG_EXP = 8'd236;
`endif

    ccd_cds_sampler_if #(.ADC_W(ADC_W)) pix ();

    ccd_cds_sampler #(
        .ADC_W           (ADC_W),
        .PIXELS_PER_LINE (PPL),
        .SETTLE          (2),
        .FIFO_DEPTH      (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .phi_p     (phi_p),
        .phi_l1    (phi_l1),
        .phi_l2    (phi_l2),
        .phi_r     (phi_r),
        .adc_data  (adc_data),
        .pix       (pix.master),
        .pix_idx   (pix_idx),
        .ovf       (ovf),
        .seq_err   (seq_err),
        .clr_err   (clr_err),
        .fsm_state (fsm_state)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic start_line();
        phi_p = 1'b1;
        step(1);
        phi_p = 1'b0;
        step(2);
    endtask

    // The ADC carries the wanted value only on the capture edge, 3 clk after the raw edge.
    task automatic sample_rst(input logic [7:0] v);
        phi_r = 1'b1;
        step(1);
        phi_r = 1'b0;
        step(3);
        adc_data = v;
        step(1);
        adc_data = '0;
    endtask

    task automatic sample_sig(input logic [7:0] v, input bit pop_at_capture);
        phi_l1 = ~phi_l1;
        phi_l2 = 1'b1;
        step(1);
        phi_l2 = 1'b0;
        step(3);
        adc_data = v;
        if (pop_at_capture) pix.pix_ready = 1'b1;
        step(1);
        adc_data = '0;
        if (pop_at_capture) pix.pix_ready = 1'b0;
    endtask

    task automatic pixel(input logic [7:0] r, input logic [7:0] s);
        sample_rst(r);
        sample_sig(s, 1'b0);
    endtask

    task automatic drain_one(input string tag, input pix_entry_t exp);
        chk({tag, "_valid"}, 32'(pix.pix_valid), 32'd1);
        chk({tag, "_data"},  32'(pix.pix_data),  32'(exp.data));
        chk({tag, "_last"},  32'(pix.pix_last),  32'(exp.last));
        pix.pix_ready = 1'b1;
        step(1);
        pix.pix_ready = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        step(1);
        clr_err = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        phi_p = 1'b0; phi_l1 = 1'b0; phi_l2 = 1'b0; phi_r = 1'b0;
        adc_data = '0; clr_err = 1'b0; pix.pix_ready = 1'b0;
        step(3);
        chk("rst_state", 32'(fsm_state), 32'(IDLE));
        chk("rst_valid", 32'(pix.pix_valid), 32'd0);
        chk("rst_data",  32'(pix.pix_data), 32'd0);
        chk("rst_last",  32'(pix.pix_last), 32'd0);
        chk("rst_idx",   32'(pix_idx), 32'd0);
        chk("rst_ovf",   32'(ovf), 32'd0);
        chk("rst_seq",   32'(seq_err), 32'd0);
        rst = 1'b0;
        step(1);

        // Nominal line, consumer always ready
        pix.pix_ready = 1'b1;
        start_line();
        chk("nom_start_state", 32'(fsm_state), 32'(WAIT_R));
        chk("nom_start_idx", 32'(pix_idx), 32'd0);
        for (int i = 0; i < PPL; i++) begin
            pixel(8'd200, 8'd50);
            chk("nom_valid", 32'(pix.pix_valid), 32'd1);
            chk("nom_data",  32'(pix.pix_data), 32'd150);
            chk("nom_last",  32'(pix.pix_last), (i == PPL - 1) ? 32'd1 : 32'd0);
            chk("nom_idx",   32'(pix_idx), 32'((i + 1) % PPL));
        end
        chk("nom_end_state", 32'(fsm_state), 32'(IDLE));
        chk("nom_ovf", 32'(ovf), 32'd0);
        chk("nom_seq", 32'(seq_err), 32'd0);
        step(1);
        chk("nom_drained", 32'(pix.pix_valid), 32'd0);

        // Backpressure: six pixels into a four-entry FIFO
        pix.pix_ready = 1'b0;
        start_line();
        for (int i = 0; i < PPL; i++) pixel(8'd100, 8'(10 * (i + 1)));
        chk("bp_full_ovf", 32'(ovf), 32'd0);
        chk("bp_head", 32'(pix.pix_data), 32'd90);
        start_line();
        pixel(8'd100, 8'd50);
        chk("bp_ovf5", 32'(ovf), 32'd1);
        chk("bp_idx5", 32'(pix_idx), 32'd1);
        pixel(8'd100, 8'd50);
        chk("bp_idx6", 32'(pix_idx), 32'd2);
        drain_one("bp_p1", '{data: 8'd90, last: 1'b0});
        drain_one("bp_p2", '{data: 8'd80, last: 1'b0});
        drain_one("bp_p3", '{data: 8'd70, last: 1'b0});
        drain_one("bp_p4", '{data: 8'd60, last: 1'b1});
        chk("bp_empty", 32'(pix.pix_valid), 32'd0);
        pix.pix_ready = 1'b1;
        pixel(8'd100, 8'd10);
        pixel(8'd100, 8'd10);
        chk("bp_tail_data", 32'(pix.pix_data), 32'd90);
        chk("bp_tail_last", 32'(pix.pix_last), 32'd1);
        step(1);
        pix.pix_ready = 1'b0;
        chk("bp_tail_idx", 32'(pix_idx), 32'd0);
        chk("bp_ovf_held", 32'(ovf), 32'd1);
        pulse_clr();
        chk("bp_ovf_clr", 32'(ovf), 32'd0);

        // Negative CDS
        pix.pix_ready = 1'b1;
        start_line();
        pixel(8'd10, 8'd30);
        chk("neg_data", 32'(pix.pix_data), 32'(NEG_EXP));
        chk("neg_last", 32'(pix.pix_last), 32'd0);
        step(1);
        pix.pix_ready = 1'b0;

        // Sequence errors
        pixel(8'd77, 8'd7);
        chk("seq_pre_idx", 32'(pix_idx), 32'd2);
        phi_l2 = 1'b1;
        step(1);
        phi_l2 = 1'b0;
        step(3);
        chk("seq_l2_flag", 32'(seq_err), 32'd1);
        chk("seq_l2_state", 32'(fsm_state), 32'(WAIT_R));
        chk("seq_l2_idx", 32'(pix_idx), 32'd2);
        pulse_clr();
        chk("seq_clr1", 32'(seq_err), 32'd0);
        sample_rst(8'd5);
        chk("seq_half_state", 32'(fsm_state), 32'(WAIT_S));
        start_line();
        chk("seq_p_flag", 32'(seq_err), 32'd1);
        chk("seq_p_idx", 32'(pix_idx), 32'd0);
        chk("seq_p_state", 32'(fsm_state), 32'(WAIT_R));
        drain_one("seq_keep", '{data: 8'd70, last: 1'b0});
        chk("seq_nothing_extra", 32'(pix.pix_valid), 32'd0);
        pulse_clr();
        chk("seq_clr2", 32'(seq_err), 32'd0);

        // Reset mid-operation
        for (int i = 0; i < 3; i++) pixel(8'd100, 8'(10 * (i + 1)));
        sample_rst(8'd100);
        phi_l2 = 1'b1;
        step(1);
        phi_l2 = 1'b0;
        step(2);
        chk("mid_state", 32'(fsm_state), 32'(SETTLE_S));
        chk("mid_valid", 32'(pix.pix_valid), 32'd1);
        rst = 1'b1;
        step(1);
        chk("mid_rst_valid", 32'(pix.pix_valid), 32'd0);
        chk("mid_rst_idx", 32'(pix_idx), 32'd0);
        chk("mid_rst_state", 32'(fsm_state), 32'(IDLE));
        chk("mid_rst_data", 32'(pix.pix_data), 32'd0);
        rst = 1'b0;
        step(1);
        pix.pix_ready = 1'b1;
        start_line();
        for (int i = 0; i < PPL; i++) begin
            pixel(8'd60, 8'd20);
            chk("clean_data", 32'(pix.pix_data), 32'd40);
            chk("clean_last", 32'(pix.pix_last), (i == PPL - 1) ? 32'd1 : 32'd0);
        end
        chk("clean_ovf", 32'(ovf), 32'd0);
        chk("clean_seq", 32'(seq_err), 32'd0);
        step(1);
        pix.pix_ready = 1'b0;

        // Push and pop in the same cycle while full
        start_line();
        for (int i = 0; i < PPL; i++) pixel(8'd100, 8'(10 * (i + 1)));
        chk("pp_head", 32'(pix.pix_data), 32'd90);
        start_line();
        sample_rst(8'd100);
        sample_sig(8'd50, 1'b1);
        chk("pp_ovf", 32'(ovf), 32'd0);
        chk("pp_idx", 32'(pix_idx), 32'd1);
        drain_one("pp_q1", '{data: 8'd80, last: 1'b0});
        drain_one("pp_q2", '{data: 8'd70, last: 1'b0});
        drain_one("pp_q3", '{data: 8'd60, last: 1'b1});
        drain_one("pp_q4", '{data: 8'd50, last: 1'b0});
        chk("pp_empty", 32'(pix.pix_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
